// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit seven-segment scan driver.
// Segment vectors are active-high, bit 0 = a ... bit 6 = g.
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 4;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef logic [1:0] digit_idx_t;

   function automatic logic [NUM_DIGITS-1:0] idx_to_onehot(input digit_idx_t idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; codes 10..15 show the letter E.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_E;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_E;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a four-digit display with a load-strobed shadow
// register, leading-zero blanking and an out-of-range flag.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4
) (
   input  logic        clk_i,
   input  logic        mr_i,
   input  logic        en_i,
   input  logic        load_i,
   input  logic [15:0] digits_i,
   input  logic        blank_lz_i,
   output logic [6:0]  seg_o,
   output logic [3:0]  an_o,
   output logic        ovf_o
);

   localparam logic [15:0] PrescMax = 16'(SCAN_DIV - 1);

   logic [15:0]           presc_q, presc_d;
   digit_idx_t            idx_q, idx_d;
   logic [15:0]           shadow_q, shadow_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  ovf_q, ovf_d;

   logic                  tick;
   logic [3:0]            cur_nibble;
   logic [6:0]            dec_seg;
   logic [NUM_DIGITS-1:0] nib_zero;
   logic [NUM_DIGITS-1:0] nib_ovf;
   logic [NUM_DIGITS-1:0] zero_from;
   logic                  blank;

   assign cur_nibble = shadow_q[{idx_q, 2'b00} +: 4];

   bcd_to_seg7 u_dec (
      .bcd_i (cur_nibble),
      .seg_o (dec_seg)
   );

   always_comb begin
      nib_zero = '0;
      nib_ovf  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         nib_zero[i] = (shadow_q[4*i +: 4] == 4'd0);
         nib_ovf[i]  = (shadow_q[4*i +: 4] > 4'd9);
      end
   end

   // zero_from[i]: every nibble from position i up to the thousands digit is zero.
   always_comb begin
      zero_from    = '0;
      zero_from[3] = nib_zero[3];
      zero_from[2] = nib_zero[2] & zero_from[3];
      zero_from[1] = nib_zero[1] & zero_from[2];
      zero_from[0] = nib_zero[0] & zero_from[1];
      blank        = blank_lz_i && (idx_q != 2'd0) && zero_from[idx_q];
   end

   always_comb begin
      tick     = en_i && (presc_q == PrescMax);
      presc_d  = presc_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      if (en_i) begin
         presc_d = tick ? 16'd0 : presc_q + 16'd1;
      end
      if (tick) begin
         idx_d = idx_q + 2'd1;
      end
      if (load_i) begin
         shadow_d = digits_i;
      end
      seg_d = blank ? SEG_BLANK : dec_seg;
      an_d  = idx_to_onehot(idx_q);
      ovf_d = |nib_ovf;
   end

   always_ff @(posedge clk_i) begin
      if (mr_i) begin
         presc_q  <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         seg_q    <= SEG_BLANK;
         an_q     <= '0;
         ovf_q    <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
         ovf_q    <= ovf_d;
      end
   end

   assign seg_o = seg_q;
   assign an_o  = an_q;
   assign ovf_o = ovf_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with SCAN_DIV = 4.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        mr;
   logic        en;
   logic        load;
   logic [15:0] digits;
   logic        blank_lz;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   seg7_scan_driver #(
      .SCAN_DIV (4)
   ) dut (
      .clk_i      (clk),
      .mr_i       (mr),
      .en_i       (en),
      .load_i     (load),
      .digits_i   (digits),
      .blank_lz_i (blank_lz),
      .seg_o      (seg),
      .an_o       (an),
      .ovf_o      (ovf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      mr   = 1'b1;
      load = 1'b0;
      en   = 1'b0;
      step();
      mr = 1'b0;
   endtask

   task automatic test_reset();
      mr       = 1'b1;
      load     = 1'b1;
      en       = 1'b1;
      digits   = 16'hFFFF;
      blank_lz = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (an !== 4'b0000 || seg !== 7'h00 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold[%0d]: an=%b seg=%h ovf=%b, expected an=0000 seg=00 ovf=0",
                     i, an, seg, ovf);
         end
      end
      mr   = 1'b0;
      en   = 1'b0;
      load = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (an !== 4'b0001 || seg !== 7'h3F || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_release[%0d]: an=%b seg=%h ovf=%b, expected an=0001 seg=3F ovf=0",
                     i, an, seg, ovf);
         end
      end
   endtask

   task automatic test_scan();
      logic [6:0] exp_seg [4];
      logic [3:0] exp_an  [4];
      exp_seg = '{7'h66, 7'h4F, 7'h5B, 7'h06};
      exp_an  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      reset_dut();
      blank_lz = 1'b0;
      digits   = 16'h1234;
      load     = 1'b1;
      step();
      load = 1'b0;
      en   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (an !== exp_an[k%4] || seg !== exp_seg[k%4]) begin
               errors++;
               $display("FAIL scan k=%0d c=%0d: an=%b seg=%h, expected an=%b seg=%h",
                        k, c, an, seg, exp_an[k%4], exp_seg[k%4]);
            end
         end
      end
   endtask

   task automatic test_blanking();
      logic [6:0] exp_a [4];
      logic [6:0] exp_b [4];
      exp_a = '{7'h3F, 7'h07, 7'h00, 7'h00};
      exp_b = '{7'h3F, 7'h00, 7'h00, 7'h00};
      for (int p = 0; p < 2; p++) begin
         reset_dut();
         blank_lz = 1'b1;
         digits   = (p == 0) ? 16'h0070 : 16'h0000;
         load     = 1'b1;
         step();
         load = 1'b0;
         en   = 1'b1;
         for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
               step();
               checks++;
               if (an !== (4'b0001 << k) || seg !== ((p == 0) ? exp_a[k] : exp_b[k])) begin
                  errors++;
                  $display("FAIL blank p=%0d k=%0d c=%0d: an=%b seg=%h, expected an=%b seg=%h",
                           p, k, c, an, seg, 4'b0001 << k, (p == 0) ? exp_a[k] : exp_b[k]);
               end
            end
         end
      end
      // Toggle blanking while digit 2 is on screen.
      reset_dut();
      blank_lz = 1'b1;
      digits   = 16'h0070;
      load     = 1'b1;
      step();
      load = 1'b0;
      en   = 1'b1;
      for (int i = 0; i < 9; i++) step();
      checks++;
      if (an !== 4'b0100 || seg !== 7'h00) begin
         errors++;
         $display("FAIL blank_toggle_on: an=%b seg=%h, expected an=0100 seg=00", an, seg);
      end
      blank_lz = 1'b0;
      step();
      checks++;
      if (an !== 4'b0100 || seg !== 7'h3F) begin
         errors++;
         $display("FAIL blank_toggle_off: an=%b seg=%h, expected an=0100 seg=3F", an, seg);
      end
   endtask

   task automatic test_overflow();
      logic [6:0] exp_nb [4];
      logic [6:0] exp_bl [4];
      exp_nb = '{7'h6D, 7'h79, 7'h3F, 7'h3F};
      exp_bl = '{7'h6D, 7'h79, 7'h00, 7'h00};
      for (int p = 0; p < 2; p++) begin
         reset_dut();
         blank_lz = (p == 1);
         digits   = 16'h00A5;
         load     = 1'b1;
         step();
         checks++;
         if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_load_edge p=%0d: ovf=%b, expected 0", p, ovf);
         end
         load = 1'b0;
         en   = 1'b1;
         for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
               step();
               checks++;
               if (an !== (4'b0001 << k) || ovf !== 1'b1 ||
                   seg !== ((p == 0) ? exp_nb[k] : exp_bl[k])) begin
                  errors++;
                  $display("FAIL ovf p=%0d k=%0d c=%0d: an=%b seg=%h ovf=%b, expected an=%b seg=%h ovf=1",
                           p, k, c, an, seg, ovf, 4'b0001 << k,
                           (p == 0) ? exp_nb[k] : exp_bl[k]);
               end
            end
         end
      end
      digits = 16'h0005;
      load   = 1'b1;
      step();
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_clear_edge: ovf=%b, expected 1", ovf);
      end
      load = 1'b0;
      step();
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: ovf=%b, expected 0", ovf);
      end
   endtask

   task automatic test_freeze();
      reset_dut();
      blank_lz = 1'b0;
      digits   = 16'h1234;
      load     = 1'b1;
      step();
      load = 1'b0;
      en   = 1'b1;
      for (int i = 0; i < 8; i++) step();
      checks++;
      if (an !== 4'b0010) begin
         errors++;
         $display("FAIL freeze_pre: an=%b, expected 0010", an);
      end
      en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) begin
            digits = 16'h5678;
            load   = 1'b1;
         end else begin
            load = 1'b0;
         end
         step();
         checks++;
         if (an !== 4'b0100 || seg !== ((i <= 10) ? 7'h5B : 7'h7D)) begin
            errors++;
            $display("FAIL freeze[%0d]: an=%b seg=%h, expected an=0100 seg=%h",
                     i, an, seg, (i <= 10) ? 7'h5B : 7'h7D);
         end
      end
      load = 1'b0;
      en   = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         checks++;
         if (an !== 4'b0100) begin
            errors++;
            $display("FAIL resume_hold[%0d]: an=%b, expected 0100", c, an);
         end
      end
      step();
      checks++;
      if (an !== 4'b1000 || seg !== 7'h6D) begin
         errors++;
         $display("FAIL resume_advance: an=%b seg=%h, expected an=1000 seg=6D", an, seg);
      end
   endtask

   task automatic test_collision();
      reset_dut();
      blank_lz = 1'b0;
      digits   = 16'h1234;
      load     = 1'b1;
      step();
      load = 1'b0;
      en   = 1'b1;
      for (int i = 0; i < 3; i++) step();
      digits = 16'hF876;
      load   = 1'b1;
      step();
      checks++;
      if (an !== 4'b0001 || seg !== 7'h66) begin
         errors++;
         $display("FAIL collide_edge: an=%b seg=%h, expected an=0001 seg=66", an, seg);
      end
      load = 1'b0;
      step();
      checks++;
      if (an !== 4'b0010 || seg !== 7'h07 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL collide_next: an=%b seg=%h ovf=%b, expected an=0010 seg=07 ovf=1",
                  an, seg, ovf);
      end
      for (int i = 0; i < 8; i++) step();
      checks++;
      if (an !== 4'b1000 || seg !== 7'h79 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL collide_idx3: an=%b seg=%h ovf=%b, expected an=1000 seg=79 ovf=1",
                  an, seg, ovf);
      end
      mr = 1'b1;
      step();
      checks++;
      if (an !== 4'b0000 || seg !== 7'h00 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL midscan_reset: an=%b seg=%h ovf=%b, expected an=0000 seg=00 ovf=0",
                  an, seg, ovf);
      end
      mr = 1'b0;
      step();
      checks++;
      if (an !== 4'b0001 || seg !== 7'h3F || ovf !== 1'b0) begin
         errors++;
         $display("FAIL midscan_restart: an=%b seg=%h ovf=%b, expected an=0001 seg=3F ovf=0",
                  an, seg, ovf);
      end
   endtask

   initial begin
      mr       = 1'b1;
      en       = 1'b0;
      load     = 1'b0;
      digits   = 16'h0000;
      blank_lz = 1'b0;
      test_reset();
      test_scan();
      test_blanking();
      test_overflow();
      test_freeze();
      test_collision();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SCAN_DIV, default 4: clk cycles per digit slot while en=1 (legal range 2..65535).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 mr  input  1  reset; synchronous, active-high.
REQ-004 en  input  1  scan enable; 0 freezes the prescaler and the digit index.
REQ-005 load  input  1  snapshot strobe; captures digits into the shadow register.
REQ-006 digits  input  16  four BCD nibbles from the cascaded decade counters; [3:0] units ... [15:12] thousands.
REQ-007 blank_lz  input  1  leading-zero blanking enable.
REQ-008 seg  output  7  segments, active-high; seg[0]=a ... seg[6]=g; registered.
REQ-009 an  output  4  digit enable, one-hot, active-high, an[i] selects nibble i; registered.
REQ-010 ovf  output  1  registered; high when any shadow nibble is greater than 9.

Function
REQ-011 The shadow register SHALL load digits on every rising edge with load=1, regardless of en.
REQ-012 The prescaler SHALL count 0..SCAN_DIV-1 only while en=1 and SHALL wrap to 0 after SCAN_DIV-1; that wrap cycle is the tick.
REQ-013 On tick the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-014 With en=0, prescaler and index SHALL hold; seg and an SHALL continue to track the shadow register and index.
REQ-015 Every non-reset cycle: an <= onehot(index); seg <= decode(shadow nibble at index); ovf <= OR over nibbles of (nibble>9).
REQ-016 Output latency: one cycle; a state change at edge N appears on seg/an/ovf at edge N+1.
REQ-017 Decode table (hex, g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; any value 10..15 = 79 (letter E).
REQ-018 With blank_lz=1, digit i (i=1..3) SHALL drive seg=00 when every shadow nibble at positions i..3 is 0; digit 0 is never blanked; an is unaffected by blanking.
REQ-019 A nibble greater than 9 counts as non-zero for blanking.
REQ-020 When load and tick occur on the same edge, both SHALL take effect; the next output reflects the new shadow value at the new index.
REQ-021 A change of blank_lz SHALL take effect on the next output update, with no other side effect.

Reset
REQ-022 With mr=1 at an edge: shadow=0000, index=0, prescaler=0, seg=00, an=0000, ovf=0. mr overrides load and en.
REQ-023 On the first edge after mr falls, the outputs SHALL be an=0001 and seg=3F.
REQ-024 Asserting mr mid-scan SHALL discard the shadow contents and restart the scan at digit 0.

Structure
REQ-025 Shared package seg7_pkg SHALL hold the digit count (4), the ten digit segment constants, SEG_E=79, and SEG_BLANK=00.
REQ-026 Sub-module bcd_to_seg7 SHALL contain the purely combinational 4-bit to 7-segment decoder (REQ-017), instantiated once.
REQ-027 Prescaler, index, shadow register, blanking logic and output registers SHALL reside in seg7_scan_driver.

Verification (SCAN_DIV=4)
REQ-028 Reset: mr=1 for 3 cycles, then mr=0 with en=0 -> an=0000, seg=00 during reset; one cycle later an=0001, seg=3F; an holds 0001 thereafter.
REQ-029 Scan: load digits=16'h1234, en=1 -> an steps 0001,0010,0100,1000,0001 every 4 cycles; seg shows 66,4F,5B,06 in that order.
REQ-030 Blanking: load 16'h0070, blank_lz=1 -> digit 0 seg=3F, digit 1 seg=07, digits 2 and 3 seg=00. Load 16'h0000 -> only digit 0 lit (3F).
REQ-031 Overflow: load 16'h00A5 -> ovf=1 one cycle after load; digit 1 seg=79; digit 2 is blanked only if blank_lz=1. Load 16'h0005 -> ovf returns to 0.
REQ-032 Freeze: drop en on the cycle the index reaches 2 -> an stays 0100 for 20 cycles. Reassert en -> advance to 1000 after 4 cycles.
REQ-033 Collisions: load coincident with tick -> the new value is displayed at the new index next cycle. mr asserted during index 3 -> all outputs zero, then an=0001, seg=3F.
